// File: rtl/load_scheduler_if.sv
// Requester/counter-side bundle for load_scheduler.
// The scheduler connects through the slave modport; the requester/counter side uses master.
interface load_scheduler_if #(
  parameter int NREQ = 3,
  parameter int N    = 64
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [N-1:0]      counter_in;
  logic              load_n;
  logic [N-1:0]      set_value;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic              busy;
  logic [2:0]        grant_id;

  modport master (
    output req, req_data, counter_in,
    input  load_n, set_value, ack, err, busy, grant_id
  );

  modport slave (
    input  req, req_data, counter_in,
    output load_n, set_value, ack, err, busy, grant_id
  );
endinterface

// File: rtl/load_scheduler.sv
// Round-robin scheduler for writes into the seconds counter: grants one requester, pulses load_n,
// optionally verifies the write by readback (LOAD_SCHEDULER_VERIFY_EN) and acknowledges.
//
// state | meaning
// IDLE  | waiting for a request, arbitrating from last+1
// LOAD  | load_n low for one cycle with the latched preset
// CHECK | readback compare, retry or fail (only with LOAD_SCHEDULER_VERIFY_EN)
// ACK   | one-cycle ack/err pulse to the granted requester
module load_scheduler #(
  parameter int NREQ      = 3,
  parameter int N         = 64,
  parameter int MAX_RETRY = 2
) (
  input logic clk,
  input logic rst,
  load_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, ACK} state_t;

  state_t          state;
  logic            load_n;
  logic [N-1:0]    set_value;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] err;
  logic            busy;
  logic [2:0]      grant_id;
  logic [2:0]      last;

  logic            pick_valid;
  logic [2:0]      pick_idx;
  logic [N-1:0]    req_arr [8];
  logic [NREQ-1:0] grant_oh;

  for (genvar i = 0; i < 8; i++) begin : g_req_arr
    if (i < NREQ) begin : g_used
      assign req_arr[i] = bus.req_data[i*N +: N];
    end else begin : g_absent
      assign req_arr[i] = '0;
    end
  end

  // Scan from last+NREQ (last itself) down to last+1 so the nearest index above last wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if ((bus.req & (NREQ'(1) << ((int'(last) + k) % NREQ))) != '0) begin
        pick_valid = 1'b1;
        pick_idx   = 3'((int'(last) + k) % NREQ);
      end
    end
  end

  assign grant_oh = NREQ'(1) << grant_id;

`ifdef LOAD_SCHEDULER_VERIFY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry_cnt;
  logic          check_ok;

  // The +1 match absorbs a counter tick landing on the load edge, including wrap to zero.
  assign check_ok = (bus.counter_in == set_value) || (bus.counter_in == set_value + N'(1));
`else
  localparam int unused_max_retry = MAX_RETRY;
  logic unused_counter;
  assign unused_counter = ^bus.counter_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      load_n    <= 1'b1;
      set_value <= '0;
      ack       <= '0;
      err       <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      last      <= 3'(NREQ - 1);
`ifdef LOAD_SCHEDULER_VERIFY_EN
      retry_cnt <= '0;
`endif
    end else begin
      load_n <= 1'b1;
      ack    <= '0;
      err    <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            set_value <= req_arr[pick_idx];
            grant_id  <= pick_idx;
            load_n    <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
`ifdef LOAD_SCHEDULER_VERIFY_EN
            retry_cnt <= '0;
`endif
          end
        end
        LOAD: begin
`ifdef LOAD_SCHEDULER_VERIFY_EN
          state <= CHECK;
`else
          ack   <= grant_oh;
          state <= ACK;
`endif
        end
`ifdef LOAD_SCHEDULER_VERIFY_EN
        CHECK: begin
          if (check_ok) begin
            ack   <= grant_oh;
            state <= ACK;
          end else if (int'(retry_cnt) < MAX_RETRY) begin
            retry_cnt <= retry_cnt + RW'(1);
            load_n    <= 1'b0;
            state     <= LOAD;
          end else begin
            ack   <= grant_oh;
            err   <= grant_oh;
            state <= ACK;
          end
        end
`endif
        ACK: begin
          last  <= grant_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.load_n    = load_n;
  assign bus.set_value = set_value;
  assign bus.ack       = ack;
  assign bus.err       = err;
  assign bus.busy      = busy;
  assign bus.grant_id  = grant_id;
endmodule

// File: tb/tb_load_scheduler.sv
// Directed bench for load_scheduler: reset, round-robin order, readback tick/wrap, stuck counter
// retries and reset mid-operation. Expectations follow the LOAD_SCHEDULER_VERIFY_EN setting.
module tb_load_scheduler;
`ifdef LOAD_SCHEDULER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   tick  = 1'b0;
  bit   stuck = 1'b0;
  logic [63:0] ctr = '0;

  load_scheduler_if #(.NREQ(3), .N(64)) bus ();

  load_scheduler #(.NREQ(3), .N(64), .MAX_RETRY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;

  // Counter model: loads on the load_n edge, optionally ticking on that same edge.
  always @(posedge clk) begin
    if (!bus.load_n) ctr <= bus.set_value + (tick ? 64'd1 : 64'd0);
  end
  always_comb bus.counter_in = stuck ? 64'd0 : ctr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called in an IDLE cycle t with req already set; runs one full sequence.
  task automatic serve(input string tag, input int gid, input logic [63:0] val,
                       input int retries, input bit err_exp);
    int loads;
    int ack_at;
    int exp_at;
    int exp_loads;
    logic [2:0] oh;
    oh        = 3'b001 << gid;
    exp_at    = VERIFY ? 3 + 2 * retries : 2;
    exp_loads = VERIFY ? 1 + retries : 1;
    loads     = 0;
    ack_at    = -1;
    for (int c = 1; c <= 12 && ack_at < 0; c++) begin
      @(posedge clk); #1;
      if (!bus.load_n) loads++;
      if (c == 1) begin
        chk({tag, "_load_n"}, 64'(bus.load_n), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        chk({tag, "_grant"}, 64'(bus.grant_id), 64'(gid));
        chk({tag, "_set"}, bus.set_value, val);
      end
      if (bus.ack != 3'b000) begin
        ack_at = c;
        chk({tag, "_ack"}, 64'(bus.ack), 64'(oh));
        chk({tag, "_err"}, 64'(bus.err), (VERIFY && err_exp) ? 64'(oh) : 64'd0);
        bus.req = bus.req & ~oh;
      end
    end
    chk({tag, "_ack_cycle"}, 64'(ack_at), 64'(exp_at));
    chk({tag, "_loads"}, 64'(loads), 64'(exp_loads));
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_idle_ack"}, 64'(bus.ack), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_load_n", 64'(bus.load_n), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_grant", 64'(bus.grant_id), 64'd0);
    chk("rst_set", bus.set_value, 64'd0);

    // single request
    bus.req_data[63:0] = 64'h66D5E000;
    bus.req = 3'b001;
    serve("single", 0, 64'h66D5E000, 0, 1'b0);

    // round-robin from reset, then 101 after last=2
    do_reset();
    bus.req_data[63:0]    = 64'h1111;
    bus.req_data[127:64]  = 64'h2222;
    bus.req_data[191:128] = 64'h3333;
    bus.req = 3'b111;
    serve("rr0", 0, 64'h1111, 0, 1'b0);
    serve("rr1", 1, 64'h2222, 0, 1'b0);
    serve("rr2", 2, 64'h3333, 0, 1'b0);
    bus.req = 3'b101;
    serve("rr5a", 0, 64'h1111, 0, 1'b0);
    serve("rr5b", 2, 64'h3333, 0, 1'b0);

    // tick lands on the load edge
    tick = 1'b1;
    bus.req_data[127:64] = 64'h66D5E000;
    bus.req = 3'b010;
    serve("tick", 1, 64'h66D5E000, 0, 1'b0);

    // stuck counter: retries exhausted
    tick  = 1'b0;
    stuck = 1'b1;
    bus.req_data[191:128] = 64'd5;
    bus.req = 3'b100;
    serve("stuck", 2, 64'd5, 2, 1'b1);

    // reset mid-operation
    stuck = 1'b0;
    bus.req_data[127:64] = 64'hABCD;
    bus.req = 3'b010;
    @(posedge clk); #1;
    if (VERIFY) begin
      @(posedge clk); #1;
    end
    do_reset();
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_load_n", 64'(bus.load_n), 64'd1);
    chk("midrst_ack", 64'(bus.ack), 64'd0);
    chk("midrst_grant", 64'(bus.grant_id), 64'd0);
    serve("midrst_again", 1, 64'hABCD, 0, 1'b0);

    // wrap: all-ones preset reads back as zero
    tick = 1'b1;
    bus.req_data[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.req = 3'b001;
    serve("wrap", 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
